// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: two-port round-robin load/store sequencer for a word-wide,
// byte-addressed data memory without byte strobes. Sub-word stores are done as
// read-modify-write. Loads are sign- or zero-extended. Misaligned, illegal-size
// and out-of-range accesses are rejected without any memory access.
module dmem_access_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [2:0]        p0_size,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [2:0]        p1_size,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic              mem_r_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [63:0] ADDR_LIMIT = 64'(MEM_DEPTH) * 64'd4;

    state_t      state;
    logic        owner;      // port that owns the access in flight
    logic        last_gnt;   // port granted most recently
    logic        cur_we;
    logic [2:0]  cur_size;
    logic [1:0]  cur_lane;
    logic [15:0] cur_wdata;  // only the sub-word part is needed after grant

    logic              sel_valid;
    logic              sel_port;
    logic              sel_we;
    logic [2:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Rejects misaligned, illegal-size and out-of-range accesses.
    function automatic logic access_err(input logic we, input logic [2:0] size,
                                        input logic [ADDR_W-1:0] addr);
        logic bad;
        if (we) begin
            case (size)
                3'b000:  bad = 1'b0;
                3'b001:  bad = addr[0];
                3'b010:  bad = (addr[1:0] != 2'b00);
                default: bad = 1'b1;
            endcase
        end else begin
            case (size)
                3'b000, 3'b100: bad = 1'b0;
                3'b001, 3'b101: bad = addr[0];
                3'b010:         bad = (addr[1:0] != 2'b00);
                default:        bad = 1'b1;
            endcase
        end
        return bad || (64'(addr) >= ADDR_LIMIT);
    endfunction

    // Selects the addressed byte/halfword of a read word and extends it.
    function automatic logic [DATA_W-1:0] load_extend(input logic [2:0] size,
                                                      input logic [1:0] lane,
                                                      input logic [DATA_W-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            3'b000:  return {{(DATA_W-8){b[7]}}, b};
            3'b100:  return {{(DATA_W-8){1'b0}}, b};
            3'b001:  return {{(DATA_W-16){h[15]}}, h};
            3'b101:  return {{(DATA_W-16){1'b0}}, h};
            default: return word;
        endcase
    endfunction

    // Overlays the store byte/halfword onto the word read from memory.
    function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] word,
                                                      input logic is_half,
                                                      input logic [1:0] lane,
                                                      input logic [15:0] wdata);
        logic [DATA_W-1:0] m;
        m = word;
        if (is_half) m[16*lane[1] +: 16] = wdata;
        else         m[8*lane +: 8]      = wdata[7:0];
        return m;
    endfunction

    // Round-robin pick between the two requesters; only meaningful in IDLE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        sel_port = 1'b0;
        if (p0_req && p1_req) sel_port = ~last_gnt;
        else if (p1_req)      sel_port = 1'b1;
        sel_valid = (state == IDLE) && !rst && (p0_req || p1_req);
        sel_we    = sel_port ? p1_we    : p0_we;
        sel_size  = sel_port ? p1_size  : p0_size;
        sel_addr  = sel_port ? p1_addr  : p0_addr;
        sel_wdata = sel_port ? p1_wdata : p0_wdata;
    end

    assign p0_gnt = sel_valid && !sel_port;
    assign p1_gnt = sel_valid &&  sel_port;

    // Access sequencer with registered port and memory-side outputs.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_gnt    <= 1'b1;  // makes port 0 win the first tie
            cur_we      <= 1'b0;
            cur_size    <= '0;
            cur_lane    <= '0;
            cur_wdata   <= '0;
            p0_done     <= 1'b0;
            p0_err      <= 1'b0;
            p0_rdata    <= '0;
            p1_done     <= 1'b0;
            p1_err      <= 1'b0;
            p1_rdata    <= '0;
            mem_r_en    <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        owner     <= sel_port;
                        last_gnt  <= sel_port;
                        cur_we    <= sel_we;
                        cur_size  <= sel_size;
                        cur_lane  <= sel_addr[1:0];
                        cur_wdata <= sel_wdata[15:0];
                        if (access_err(sel_we, sel_size, sel_addr)) begin
                            state <= RESP;
                            if (sel_port) begin p1_done <= 1'b1; p1_err <= 1'b1; end
                            else          begin p0_done <= 1'b1; p0_err <= 1'b1; end
                        end else if (!sel_we || sel_size[1:0] != 2'b10) begin
                            state    <= RD;
                            mem_r_en <= 1'b1;
                            mem_addr <= ADDR_W'(sel_addr[ADDR_W-1:2]);
                        end else begin
                            state       <= WR;
                            mem_wr_en   <= 1'b1;
                            mem_addr    <= ADDR_W'(sel_addr[ADDR_W-1:2]);
                            mem_data_in <= sel_wdata;
                        end
                    end
                end
                RD: begin
                    mem_r_en <= 1'b0;
                    if (!cur_we) begin
                        state    <= RESP;
                        mem_addr <= '0;
                        if (owner) begin
                            p1_done  <= 1'b1;
                            p1_rdata <= load_extend(cur_size, cur_lane, mem_data_out);
                        end else begin
                            p0_done  <= 1'b1;
                            p0_rdata <= load_extend(cur_size, cur_lane, mem_data_out);
                        end
                    end else begin
                        state       <= WR;
                        mem_wr_en   <= 1'b1;
                        mem_data_in <= store_merge(mem_data_out, cur_size[0], cur_lane, cur_wdata);
                    end
                end
                WR: begin
                    state       <= RESP;
                    mem_wr_en   <= 1'b0;
                    mem_addr    <= '0;
                    mem_data_in <= '0;
                    if (owner) p1_done <= 1'b1;
                    else       p0_done <= 1'b1;
                end
                RESP: begin
                    state    <= IDLE;
                    p0_done  <= 1'b0;
                    p0_err   <= 1'b0;
                    p0_rdata <= '0;
                    p1_done  <= 1'b0;
                    p1_err   <= 1'b0;
                    p1_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl: directed scenarios plus two concurrent random
// requesters. A word-level reference model predicts each response at grant time
// and a monitor compares responses, latency and memory-enable counts.
module tb_dmem_access_ctrl;

    localparam int ADDR_W    = 32;
    localparam int MEM_DEPTH = 2048;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nr;
        int          nw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [2];
    logic        we    [2];
    logic [2:0]  size  [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];

    logic        p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_r_en, mem_wr_en;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;

    logic [31:0] mem     [MEM_DEPTH];
    logic [31:0] ref_mem [MEM_DEPTH];

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int gnt_cycle = 0;
    int nr_cnt = 0;
    int nw_cnt = 0;
    logic last_w = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    dmem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .p0_req(req[0]), .p0_we(we[0]), .p0_size(size[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(req[1]), .p1_we(we[1]), .p1_size(size[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_r_en(mem_r_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    // Data memory: combinational read, write on the falling edge.
    assign mem_data_out = (mem_addr < 32'(MEM_DEPTH)) ? mem[mem_addr[10:0]] : 32'h0;
    always @(negedge clk) if (mem_wr_en && mem_addr < 32'(MEM_DEPTH)) mem[mem_addr[10:0]] <= mem_data_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference model: decides the outcome from the access rules and updates ref_mem.
    task automatic model_access(input logic w, input logic [2:0] sz, input logic [31:0] a,
                                input logic [31:0] wd, output exp_t e);
        int unsigned lane;
        logic [31:0] word, v, mask;
        logic bad;
        lane = a % 4;
        if (w) bad = !(sz == 3'd0 || sz == 3'd1 || sz == 3'd2);
        else   bad = !(sz == 3'd0 || sz == 3'd1 || sz == 3'd2 || sz == 3'd4 || sz == 3'd5);
        if ((sz == 3'd1 || sz == 3'd5) && (a % 2) != 0) bad = 1'b1;
        if (sz == 3'd2 && lane != 0) bad = 1'b1;
        if (a >= 32'(4 * MEM_DEPTH)) bad = 1'b1;
        e.rdata = 32'h0; e.err = 1'b0;
        if (bad) begin
            e.err = 1'b1; e.lat = 1; e.nr = 0; e.nw = 0;
            return;
        end
        word = ref_mem[a / 4];
        if (!w) begin
            e.lat = 2; e.nr = 1; e.nw = 0;
            case (sz)
                3'd0: begin v = (word >> (8 * lane)) & 32'hff;                 if (v >= 32'h80)   v = v - 32'h100;   end
                3'd4:        v = (word >> (8 * lane)) & 32'hff;
                3'd1: begin v = (word >> (16 * (lane / 2))) & 32'hffff;        if (v >= 32'h8000) v = v - 32'h10000; end
                3'd5:        v = (word >> (16 * (lane / 2))) & 32'hffff;
                default:     v = word;
            endcase
            e.rdata = v;
        end else if (sz == 3'd2) begin
            e.lat = 2; e.nr = 0; e.nw = 1;
            ref_mem[a / 4] = wd;
        end else begin
            e.lat = 3; e.nr = 1; e.nw = 1;
            if (sz == 3'd0) begin
                mask = 32'hff << (8 * lane);
                ref_mem[a / 4] = (word & ~mask) | ((wd & 32'hff) << (8 * lane));
            end else begin
                mask = 32'hffff << (16 * (lane / 2));
                ref_mem[a / 4] = (word & ~mask) | ((wd & 32'hffff) << (16 * (lane / 2)));
            end
        end
    endtask

    // One access from port p: request, wait for grant, predict, wait for done.
    task automatic issue(input int p, input logic w, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] got_rdata, output logic got_err);
        exp_t e;
        bit granted = 0;
        bit finished = 0;
        got_rdata = 32'h0;
        got_err = 1'b0;
        req[p] = 1'b1; we[p] = w; size[p] = sz; addr[p] = a; wdata[p] = wd;
        for (int i = 0; i < 100 && !granted; i++) begin
            @(negedge clk);
            if (p == 0 ? p0_gnt : p1_gnt) granted = 1;
        end
        if (!granted) begin
            checks++; errors++;
            $display("FAIL grant_timeout: port %0d got no gnt within 100 cycles", p);
            req[p] = 1'b0;
            return;
        end
        model_access(w, sz, a, wd, e);
        if (p == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        @(posedge clk); #1;
        req[p] = 1'b0; we[p] = 1'($urandom); size[p] = 3'($urandom); addr[p] = $urandom; wdata[p] = $urandom;
        for (int i = 0; i < 20 && !finished; i++) begin
            @(negedge clk);
            if (p == 0 ? p0_done : p1_done) begin
                finished = 1;
                got_rdata = p == 0 ? p0_rdata : p1_rdata;
                got_err   = p == 0 ? p0_err   : p1_err;
            end
        end
        if (!finished) begin
            checks++; errors++;
            $display("FAIL done_timeout: port %0d got no done within 20 cycles", p);
        end
    endtask

    // Monitor: arbitration order, enable counts, latency and response contents.
    always @(negedge clk) begin
        exp_t e;
        logic exp_w;
        if (rst) begin
            last_w = 1'b1;
        end else begin
            if (p0_gnt || p1_gnt) begin
                check("single_gnt", 32'(p0_gnt && p1_gnt), 32'h0);
                exp_w = (req[0] && req[1]) ? ~last_w : req[1];
                check("arb_winner_p1", 32'(p1_gnt), 32'(exp_w));
                last_w = exp_w;
                gnt_cycle = cycle; nr_cnt = 0; nw_cnt = 0;
            end
            if (mem_r_en) nr_cnt++;
            if (mem_wr_en) nw_cnt++;
            if (!mem_r_en && !mem_wr_en) check("mem_addr_idle_zero", mem_addr, 32'h0);
            if (!mem_wr_en) check("mem_data_in_idle_zero", mem_data_in, 32'h0);
            if (!p0_done) check("p0_rdata_idle_zero", p0_rdata, 32'h0);
            if (!p1_done) check("p1_rdata_idle_zero", p1_rdata, 32'h0);
            for (int p = 0; p < 2; p++) begin
                if (p == 0 ? p0_done : p1_done) begin
                    if ((p == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        checks++; errors++;
                        $display("FAIL spurious_done: port %0d done with nothing outstanding", p);
                    end else begin
                        e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check($sformatf("p%0d_rdata", p), p == 0 ? p0_rdata : p1_rdata, e.rdata);
                        check($sformatf("p%0d_err", p), 32'(p == 0 ? p0_err : p1_err), 32'(e.err));
                        check($sformatf("p%0d_latency", p), 32'(cycle - gnt_cycle), 32'(e.lat));
                        check($sformatf("p%0d_rd_cycles", p), 32'(nr_cnt), 32'(e.nr));
                        check($sformatf("p%0d_wr_cycles", p), 32'(nw_cnt), 32'(e.nw));
                    end
                end
            end
        end
    end

    task automatic random_port(input int p, input int n);
        logic [31:0] a, r;
        logic er;
        int sel;
        for (int i = 0; i < n; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = $urandom;
            else if (sel == 1) a = 32'(4 * MEM_DEPTH - 4) + $urandom_range(0, 7);
            else               a = $urandom_range(0, 127);
            issue(p, 1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, r, er);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] r0, r1;
    logic        e0, e1;
    bit          seen_gnt;

    initial begin
        rst = 1'b1;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; size[p] = 3'd0; addr[p] = 32'h0; wdata[p] = 32'h0;
        end
        for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[3] = 32'h00abcd00; ref_mem[3] = 32'h00abcd00;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_p0_done", 32'(p0_done), 32'h0);
        check("rst_p1_done", 32'(p1_done), 32'h0);
        check("rst_p0_err", 32'(p0_err), 32'h0);
        check("rst_p1_err", 32'(p1_err), 32'h0);
        check("rst_mem_r_en", 32'(mem_r_en), 32'h0);
        check("rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Both ports request continuously from reset: grants must alternate p0 first.
        fork
            begin issue(0, 1'b0, 3'b010, 32'h0C, 32'h0, r0, e0); issue(0, 1'b0, 3'b010, 32'h00, 32'h0, r0, e0); end
            begin issue(1, 1'b0, 3'b010, 32'h04, 32'h0, r1, e1); issue(1, 1'b0, 3'b010, 32'h08, 32'h0, r1, e1); end
        join

        // Load extension on word 3 = 0x00abcd00.
        issue(0, 1'b0, 3'b000, 32'h0D, 32'h0, r0, e0); check("lb_0D", r0, 32'hffffffcd);
        issue(0, 1'b0, 3'b100, 32'h0D, 32'h0, r0, e0); check("lbu_0D", r0, 32'h000000cd);
        issue(0, 1'b0, 3'b001, 32'h0C, 32'h0, r0, e0); check("lh_0C", r0, 32'hffffcd00);
        issue(0, 1'b0, 3'b101, 32'h0E, 32'h0, r0, e0); check("lhu_0E", r0, 32'h000000ab);

        // Sub-word store via read-modify-write, then word store.
        issue(0, 1'b1, 3'b000, 32'h0F, 32'h11, r0, e0);
        issue(0, 1'b0, 3'b010, 32'h0C, 32'h0, r0, e0); check("lw_after_sb", r0, 32'h11abcd00);
        issue(0, 1'b1, 3'b010, 32'h10, 32'hdeadbeef, r0, e0);
        issue(0, 1'b0, 3'b010, 32'h10, 32'h0, r0, e0); check("lw_after_sw", r0, 32'hdeadbeef);

        // Rejected accesses.
        issue(0, 1'b0, 3'b010, 32'h0E, 32'h0, r0, e0);   check("err_lw_misaligned", 32'(e0), 32'h1);
        issue(1, 1'b0, 3'b001, 32'h01, 32'h0, r1, e1);   check("err_lh_misaligned", 32'(e1), 32'h1);
        issue(0, 1'b0, 3'b010, 32'h2000, 32'h0, r0, e0); check("err_out_of_range", 32'(e0), 32'h1);
        issue(1, 1'b1, 3'b011, 32'h20, 32'h5, r1, e1);   check("err_store_size", 32'(e1), 32'h1);
        check("err_store_rdata", r1, 32'h0);

        // Reset during the RD cycle of an sb: no write, no done.
        req[0] = 1'b1; we[0] = 1'b1; size[0] = 3'b000; addr[0] = 32'h0C; wdata[0] = 32'h55;
        seen_gnt = 0;
        for (int i = 0; i < 20 && !seen_gnt; i++) begin
            @(negedge clk);
            if (p0_gnt) seen_gnt = 1;
        end
        check("rst_test_gnt", 32'(seen_gnt), 32'h1);
        @(posedge clk); #1 req[0] = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("midrst_mem_r_en", 32'(mem_r_en), 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("midrst_mem_wr_en", 32'(mem_wr_en), 32'h0);
            check("midrst_p0_done", 32'(p0_done), 32'h0);
        end
        @(posedge clk); #1 rst = 1'b0;
        issue(0, 1'b0, 3'b010, 32'h0C, 32'h0, r0, e0); check("lw_after_midrst", r0, 32'h11abcd00);

        // Random traffic from both ports at once.
        fork
            random_port(0, 150);
            random_port(1, 150);
        join

        repeat (5) @(negedge clk);
        check("p0_queue_drained", 32'(exp_q0.size()), 32'h0);
        check("p1_queue_drained", 32'(exp_q1.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencing controller between two load/store requesters (core LSU on port 0, DMA/debug on port 1) and the word-wide, byte-addressed data memory. It arbitrates round-robin and decodes RISC-V `funct3` access sizes. Because the memory has no byte strobes, it performs read-modify-write for sub-word stores. It also sign- or zero-extends loads and reports misaligned or out-of-range accesses without touching memory.

## Interface
Parameters:
- `ADDR_W`, 32: requester byte-address width.
- `DATA_W`, 32: data width; fixed at 32.
- `MEM_DEPTH`, 2048: memory depth in 32-bit words.

Ports (`pN_` = `p0_` core and `p1_` DMA, identical sets):
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `pN_req`  in  1: access request; hold until `pN_gnt`.
- `pN_we`  in  1: 1 = store, 0 = load.
- `pN_size`  in  3: RISC-V `funct3`. Loads: `000` lb, `001` lh, `010` lw, `100` lbu, `101` lhu. Stores: `000` sb, `001` sh, `010` sw.
- `pN_addr`  in  ADDR_W: byte address.
- `pN_wdata`  in  32: store data, right-aligned.
- `pN_gnt`  out  1: request accepted this cycle; fields are sampled this cycle.
- `pN_done`  out  1: one-cycle completion pulse.
- `pN_rdata`  out  32: extended load data, valid while `pN_done`; 0 otherwise.
- `pN_err`  out  1: valid with `pN_done`; access was rejected.
- `mem_r_en`  out  1: memory read enable.
- `mem_wr_en`  out  1: memory write enable; memory writes on the falling edge.
- `mem_addr`  out  ADDR_W: word index = `addr[ADDR_W-1:2]`, zero-extended.
- `mem_data_in`  out  32: word to write.
- `mem_data_out`  in  32: combinational read data.

## Operation
States:
- `IDLE`
  - Arbitrate between requesters.
  - On grant, register owner, `we`, `size`, `addr`, and `wdata`.
  - Next state: error → `RESP`; load or sub-word store → `RD`; sw → `WR`.
- `RD`
  - `mem_r_en=1`; capture `mem_data_out` at the rising edge.
  - Next state: load → `RESP`; sub-word store → `WR`.
- `WR`
  - `mem_wr_en=1` with `mem_data_in` = merged word (sub-word) or `wdata` (sw).
  - Next state: `RESP`.
- `RESP`
  - Assert owner's `done`, plus `rdata`/`err`.
  - Next state: `IDLE` (no back-to-back accept).

Arbitration:
- One requester active: it wins.
- Both active: the port not granted most recently wins.
- After reset, priority is port 0.
- `gnt` is combinational in `IDLE` only; at most one `gnt` per cycle.

Errors (no memory enable asserted):
- Misaligned: lh/lhu/sh with `addr[0]=1`; lw/sw with `addr[1:0]!=0`.
- Illegal `size`: load `011`, `110`, `111`; store any value other than `000`, `001`, `010`.
- Out of range: `addr >= 4*MEM_DEPTH`.
- On error, `rdata=0`, `err=1`.

Load extension (lane = `addr[1:0]`):
- lb/lbu: byte `[8*lane+7 : 8*lane]`, sign- or zero-extended.
- lh/lhu: halfword selected by `addr[1]`, sign- or zero-extended.
- lw: whole word.

Store merge: sb replaces byte lane `addr[1:0]` with `wdata[7:0]`; sh replaces halfword `addr[1]` with `wdata[15:0]`. All other bits come from the captured read word.

Memory-side outputs are 0 whenever their enable is low.

## Timing
Grant occurs in cycle T; latencies to `done`:
- Error: `done` at T+1.
- Load: `RD` T+1, `done` T+2.
- sw: `WR` T+1, `done` T+2.
- sb/sh: `RD` T+1, `WR` T+2, `done` T+3.

Reset (asynchronous, takes effect immediately):
- State `IDLE`, priority pointer to port 0.
- All outputs 0.
- Captured registers cleared.

Reset mid-operation:
- The access is abandoned with no `done`.
- `mem_wr_en` drops immediately, so a write is suppressed if reset rises before the falling edge of the `WR` cycle.

Handshake rules:
- A requester may change its fields freely after `gnt`.
- A requester may re-request in the cycle after its `done`.
- A request present during `RD`/`WR`/`RESP` waits, unacknowledged.
- A simultaneous request from the owner during `RESP` is considered in the next `IDLE` under normal round-robin.

## Test plan
- Word 3 = `0x00abcd00`; p0 loads at `0x0D`: lb → `0xffffffcd`, `done` at T+2. lbu → `0x000000cd`. lh `0x0C` → `0xffffcd00`. lhu `0x0E` → `0x000000ab`.
- p0 sb `0x0F`, `wdata=0x11`: `mem_r_en` at T+1, `mem_wr_en` at T+2 with `0x11abcd00`, `done` at T+3. A following lw `0x0C` returns `0x11abcd00`.
- p0 sw `0x10`, `wdata=0xdeadbeef`: `mem_wr_en` at T+1 only, never `mem_r_en`. Read back returns `0xdeadbeef`.
- p0 lw `0x0E`, p1 lh `0x01`, p0 lw `0x2000`, p1 store `size=011`: each gives `err=1`, `rdata=0`, `done` at T+1, and no memory enable.
- p0 and p1 request continuously from reset: grants p0, p1, p0, p1, with `done` pulses on the matching port only.
- sb in progress, `rst` asserted during `RD`: no `mem_wr_en`, no `done`, outputs 0. Memory word unchanged; the next request is granted normally.
